// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the vector-capable pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package core_pkg;

    localparam int XLEN_C  = 32;
    localparam int WIDTH_C = 128;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Write-back result select encodings
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mem_beat_sequencer.sv
// ============================================================================
// Module      : mem_beat_sequencer
// Description : Splits a WIDTH-bit access into XLEN-bit beats on the dmem port
//               and assembles load data.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_beat_sequencer
    import core_pkg::*;
#(
    parameter int WIDTH = WIDTH_C,
    parameter int XLEN  = XLEN_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             access_i,
    input  logic             write_i,
    input  logic             vector_i,
    input  logic [29:0]      addr_word_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [31:0]      dmem_addr_o,
    output logic [XLEN-1:0]  dmem_wdata_o,
    input  logic             dmem_ready_i,
    input  logic [XLEN-1:0]  dmem_rdata_i,
    output logic             done_o,
    output logic [WIDTH-1:0] read_data_o
);

    localparam int              BEATS    = WIDTH / XLEN;
    localparam int              BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]   LAST_VEC = BW'(BEATS - 1);

    mem_state_t        state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [WIDTH-1:0]  buf_q, buf_d;
    logic [BW-1:0]     last_idx;

    assign last_idx     = vector_i ? LAST_VEC : '0;
    assign done_o       = access_i && dmem_ready_i && (beat_q == last_idx);
    assign dmem_req_o   = access_i;
    assign dmem_we_o    = access_i && write_i;
    assign dmem_addr_o  = {addr_word_i + 30'(beat_q), 2'b00};

    always_comb begin
        dmem_wdata_o = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BW'(i)) begin
                dmem_wdata_o = wdata_i[XLEN*i +: XLEN];
            end
        end
    end

    // The final beat's data is merged combinationally so WB can capture the
    // complete value on the same edge that accepts that beat.
    always_comb begin
        read_data_o = buf_q;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BW'(i)) begin
                read_data_o[XLEN*i +: XLEN] = dmem_rdata_i;
            end
        end
        if (!vector_i) begin
            read_data_o = {{(WIDTH-XLEN){1'b0}}, dmem_rdata_i};
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        if (!access_i) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            unique case (state_q)
                IDLE:    state_d = done_o ? IDLE : BUSY;
                BUSY:    state_d = done_o ? IDLE : BUSY;
                default: state_d = IDLE;
            endcase
            if (dmem_ready_i) begin
                beat_d = done_o ? '0 : beat_q + 1'b1;
                if (!write_i) begin
                    buf_d = read_data_o;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            buf_q   <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stage_memory.sv
// ============================================================================
// Module      : stage_memory
// Description : MEM stage - scalar/vector loads and stores over a 32-bit
//               dmem port, stall generation and MEM/WB register.
//               Optional macro MEM_MISALIGN_CHECK_EN adds mem_misaligned.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module stage_memory
    import core_pkg::*;
#(
    parameter int WIDTH = WIDTH_C,
    parameter int XLEN  = XLEN_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_clear,
    input  logic [31:0]      mem_instr,
    input  logic             mem_reg_write,
    input  logic             mem_mem_write,
    input  logic             mem_mem_read,
    input  logic [1:0]       mem_result_src,
    input  logic             mem_vector_op,
    input  logic [WIDTH-1:0] mem_alu_result,
    input  logic [WIDTH-1:0] mem_write_data,
    input  logic [31:0]      mem_pc_plus_4,
    input  logic [WIDTH-1:0] mem_imm_ext,
    input  logic [4:0]       mem_rd,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic             mem_misaligned,
`endif
    output logic             mem_stall_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [31:0]      wb_instr,
    output logic             wb_reg_write,
    output logic [1:0]       wb_result_src,
    output logic             wb_vector_op,
    output logic [WIDTH-1:0] wb_alu_result,
    output logic [WIDTH-1:0] wb_read_data,
    output logic [31:0]      wb_pc_plus_4,
    output logic [WIDTH-1:0] wb_imm_ext,
    output logic [4:0]       wb_rd
);

    logic             access_raw;
    logic             access;
    logic             misaligned;
    logic             done;
    logic [WIDTH-1:0] read_data;

    assign access_raw = mem_mem_read | mem_mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned     = access_raw && (mem_alu_result[1:0] != 2'b00);
    assign mem_misaligned = misaligned;
`else
    assign misaligned     = 1'b0;
`endif

    // A misaligned access is dropped entirely: no bus traffic and no stall.
    assign access        = access_raw && !misaligned;
    assign mem_stall_req = access && !done;

    mem_beat_sequencer #(
        .WIDTH (WIDTH),
        .XLEN  (XLEN)
    ) u_seq (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (wb_clear),
        .access_i     (access),
        .write_i      (mem_mem_write),
        .vector_i     (mem_vector_op),
        .addr_word_i  (mem_alu_result[31:2]),
        .wdata_i      (mem_write_data),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_ready_i (dmem_ready),
        .dmem_rdata_i (dmem_rdata),
        .done_o       (done),
        .read_data_o  (read_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_instr      <= '0;
            wb_reg_write  <= 1'b0;
            wb_result_src <= '0;
            wb_vector_op  <= 1'b0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            wb_pc_plus_4  <= '0;
            wb_imm_ext    <= '0;
            wb_rd         <= '0;
        end else if (wb_clear) begin
            wb_instr      <= '0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
        end else if (!mem_stall_req) begin
            wb_instr      <= mem_instr;
            wb_reg_write  <= mem_reg_write && !misaligned;
            wb_result_src <= mem_result_src;
            wb_vector_op  <= mem_vector_op;
            wb_alu_result <= mem_alu_result;
            wb_read_data  <= read_data;
            wb_pc_plus_4  <= mem_pc_plus_4;
            wb_imm_ext    <= mem_imm_ext;
            wb_rd         <= mem_rd;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stage_memory.sv
// ============================================================================
// Module      : tb_stage_memory
// Description : Directed self-checking bench for stage_memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stage_memory;

    logic         clk = 1'b0;
    logic         reset;
    logic         wb_clear;
    logic [31:0]  mem_instr;
    logic         mem_reg_write;
    logic         mem_mem_write;
    logic         mem_mem_read;
    logic [1:0]   mem_result_src;
    logic         mem_vector_op;
    logic [127:0] mem_alu_result;
    logic [127:0] mem_write_data;
    logic [31:0]  mem_pc_plus_4;
    logic [127:0] mem_imm_ext;
    logic [4:0]   mem_rd;
    logic         mem_stall_req;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic         dmem_ready;
    logic [31:0]  dmem_rdata;
    logic [31:0]  wb_instr;
    logic         wb_reg_write;
    logic [1:0]   wb_result_src;
    logic         wb_vector_op;
    logic [127:0] wb_alu_result;
    logic [127:0] wb_read_data;
    logic [31:0]  wb_pc_plus_4;
    logic [127:0] wb_imm_ext;
    logic [4:0]   wb_rd;
`ifdef MEM_MISALIGN_CHECK_EN
    logic         mem_misaligned;
`endif

    logic         use_fixed;
    logic [31:0]  fixed_rdata;
    int           n_checks = 0;
    int           n_errors = 0;
    int           stalls;

    // Memory model: read data encodes the beat address unless overridden.
    assign dmem_rdata = use_fixed ? fixed_rdata : {dmem_addr[15:0], 16'hA5A5};

    always #5 clk = ~clk;

    stage_memory dut (
        .clk            (clk),
        .reset          (reset),
        .wb_clear       (wb_clear),
        .mem_instr      (mem_instr),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_write  (mem_mem_write),
        .mem_mem_read   (mem_mem_read),
        .mem_result_src (mem_result_src),
        .mem_vector_op  (mem_vector_op),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .mem_pc_plus_4  (mem_pc_plus_4),
        .mem_imm_ext    (mem_imm_ext),
        .mem_rd         (mem_rd),
`ifdef MEM_MISALIGN_CHECK_EN
        .mem_misaligned (mem_misaligned),
`endif
        .mem_stall_req  (mem_stall_req),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .wb_instr       (wb_instr),
        .wb_reg_write   (wb_reg_write),
        .wb_result_src  (wb_result_src),
        .wb_vector_op   (wb_vector_op),
        .wb_alu_result  (wb_alu_result),
        .wb_read_data   (wb_read_data),
        .wb_pc_plus_4   (wb_pc_plus_4),
        .wb_imm_ext     (wb_imm_ext),
        .wb_rd          (wb_rd)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic rw, input logic rd_en,
                         input logic wr_en, input logic vec, input logic [31:0] addr,
                         input logic [127:0] wdata, input logic [4:0] rd);
        mem_instr      = instr;
        mem_reg_write  = rw;
        mem_mem_read   = rd_en;
        mem_mem_write  = wr_en;
        mem_vector_op  = vec;
        mem_alu_result = {96'h0, addr};
        mem_write_data = wdata;
        mem_result_src = rd_en ? 2'b01 : 2'b00;
        mem_pc_plus_4  = instr + 32'd4;
        mem_imm_ext    = {96'h0, instr};
        mem_rd         = rd;
    endtask

    task automatic nop();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 128'h0, 5'd0);
    endtask

    initial begin
        logic [31:0] st_lane [4];
        logic [31:0] ld_addr [6];
        logic        ld_rdy  [6];
        st_lane = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};
        ld_addr = '{32'h300, 32'h304, 32'h308, 32'h308, 32'h308, 32'h30C};
        ld_rdy  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; wb_clear = 1'b0; dmem_ready = 1'b1;
        use_fixed = 1'b0; fixed_rdata = 32'h0;
        nop();
        tick(); tick();
        check_eq("rst_wb_reg_write", wb_reg_write, 0);
        check_eq("rst_wb_read_data", wb_read_data, 0);
        check_eq("rst_wb_rd", wb_rd, 0);
        check_eq("rst_dmem_req", dmem_req, 0);
        reset = 1'b0;

        // Non-memory instructions: no request, no stall, WB every cycle
        drive(32'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 128'h0, 5'd4);
        #1;
        check_eq("nomem_req", dmem_req, 0);
        check_eq("nomem_stall", mem_stall_req, 0);
        tick();
        check_eq("nomem_wb_alu", wb_alu_result, 128'h1234);
        check_eq("nomem_wb_rd", wb_rd, 4);
        drive(32'h0B, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 128'h0, 5'd6);
        tick();
        check_eq("nomem_wb_rd2", wb_rd, 6);

        // Read and write both set: the write wins
        drive(32'h0C, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 128'hCAFE, 5'd0);
        #1;
        check_eq("rw_we", dmem_we, 1);
        check_eq("rw_wdata", dmem_wdata, 32'hCAFE);
        check_eq("rw_stall", mem_stall_req, 0);
        tick();

        // 1: scalar load, zero stall cycles
        use_fixed = 1'b1; fixed_rdata = 32'hDEADBEEF;
        drive(32'h11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 128'h0, 5'd5);
        #1;
        check_eq("sld_req", dmem_req, 1);
        check_eq("sld_we", dmem_we, 0);
        check_eq("sld_addr", dmem_addr, 32'h100);
        check_eq("sld_stall", mem_stall_req, 0);
        tick();
        use_fixed = 1'b0;
        check_eq("sld_wb_data", wb_read_data, 128'hDEADBEEF);
        check_eq("sld_wb_rd", wb_rd, 5);
        check_eq("sld_wb_rw", wb_reg_write, 1);

        // 2: vector store, 4 beats, 3 stall cycles
        drive(32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200,
              128'h00004444_00003333_00002222_00001111, 5'd0);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("vst_addr%0d", i), dmem_addr, 32'h200 + 32'(4*i));
            check_eq($sformatf("vst_wdata%0d", i), dmem_wdata, st_lane[i]);
            check_eq($sformatf("vst_we%0d", i), dmem_we, 1);
            if (mem_stall_req) stalls++;
            if (i == 2) check_eq("vst_wb_hold", wb_instr, 32'h11);
            tick();
        end
        check_eq("vst_stalls", stalls, 3);
        check_eq("vst_wb_instr", wb_instr, 32'h22);
        check_eq("vst_wb_rw", wb_reg_write, 0);

        // 3: vector load with ready low for 2 cycles on beat 2
        drive(32'h33, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 128'h0, 5'd7);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            dmem_ready = ld_rdy[i];
            #1;
            check_eq($sformatf("vld_addr%0d", i), dmem_addr, ld_addr[i]);
            if (mem_stall_req) stalls++;
            tick();
        end
        dmem_ready = 1'b1;
        check_eq("vld_stalls", stalls, 5);
        check_eq("vld_wb_data", wb_read_data,
                 128'h030CA5A5_0308A5A5_0304A5A5_0300A5A5);
        check_eq("vld_wb_rd", wb_rd, 7);
        check_eq("vld_wb_src", wb_result_src, 2'b01);

        // 4: wb_clear during beat 1 aborts the access
        drive(32'h44, 1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 128'h0, 5'd8);
        tick();
        check_eq("clr_beat1_addr", dmem_addr, 32'h404);
        check_eq("clr_wb_hold_rd", wb_rd, 7);
        wb_clear = 1'b1;
        tick();
        wb_clear = 1'b0;
        nop();
        #1;
        check_eq("clr_wb_rw", wb_reg_write, 0);
        check_eq("clr_wb_rd", wb_rd, 0);
        check_eq("clr_wb_instr", wb_instr, 0);
        check_eq("clr_req", dmem_req, 0);
        drive(32'h55, 1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 128'h0, 5'd3);
        #1;
        check_eq("clr_next_addr", dmem_addr, 32'h500);
        for (int i = 0; i < 4; i++) tick();
        check_eq("clr_next_data", wb_read_data,
                 128'h050CA5A5_0508A5A5_0504A5A5_0500A5A5);

        // 5: reset during beat 2
        drive(32'h66, 1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 128'h0, 5'd9);
        tick(); tick();
        check_eq("rst_mid_addr", dmem_addr, 32'h608);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nop();
        #1;
        check_eq("rstm_wb_rw", wb_reg_write, 0);
        check_eq("rstm_wb_rd", wb_rd, 0);
        check_eq("rstm_wb_data", wb_read_data, 0);
        check_eq("rstm_wb_alu", wb_alu_result, 0);
        check_eq("rstm_req", dmem_req, 0);
        check_eq("rstm_stall", mem_stall_req, 0);
        drive(32'h77, 1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 128'h0, 5'd2);
        #1;
        check_eq("rstm_next_addr", dmem_addr, 32'h700);
        for (int i = 0; i < 4; i++) tick();
        check_eq("rstm_next_data", wb_read_data,
                 128'h070CA5A5_0708A5A5_0704A5A5_0700A5A5);

`ifdef MEM_MISALIGN_CHECK_EN
        // 6: misaligned access is suppressed
        drive(32'h88, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102, 128'h0, 5'd10);
        #1;
        check_eq("mis_flag", mem_misaligned, 1);
        check_eq("mis_req", dmem_req, 0);
        check_eq("mis_stall", mem_stall_req, 0);
        tick();
        check_eq("mis_wb_rw", wb_reg_write, 0);
        check_eq("mis_wb_instr", wb_instr, 32'h88);
`endif

        nop();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
